// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg
// Constants shared by the prefetch stage and the execute-stage decoder:
// default address/data widths and the position/value of the halt opcode.
package instr_prefetch_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;

  // Opcode field of an instruction word
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  // halt/dump: stops the fetch stream once it is enqueued
  localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(31);

  function automatic logic is_halt_opcode(input logic [OPC_W-1:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_prefetch_fifo.sv
// prefetch_fifo
// Small circular buffer of {instruction, pc} entries for the prefetch stage.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push, i_din  write i_din at the tail (caller guarantees not full)
//   i_pop          remove the head (ignored when empty)
//   i_flush        discard all entries; wins over push/pop
//   o_valid        buffer is non-empty
//   o_head         head entry, read straight from storage registers
//   o_count        number of entries, 0..DEPTH
module prefetch_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 41,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch
// Instruction prefetch stage feeding the execute stage. Owns the fetch PC,
// issues sequential reads to a one-cycle-latency instruction memory, buffers
// returned words with their PCs and hands them over on a valid/ready link.
// Execute-stage redirects flush the buffer and restart fetch; an enqueued
// halt opcode stops fetching until the next redirect.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_req, mem_addr           instruction memory read request/address
//   mem_rdata                   read data, one cycle after mem_req
//   redirect_valid, redirect_pc PC change from execute stage
//   out_valid, out_ready        handshake to execute stage
//   out_instr, out_pc           head instruction and its PC
//   halted                      fetch stopped by a halt opcode
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = DATA_W + ADDR_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_halted;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_used;
  logic              w_fifo_valid;
  logic [ENT_W-1:0]  w_head;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_halt_hit;

  // Credit counts the in-flight word against the buffer, using occupancy
  // before this cycle's pop; a full buffer therefore costs one bubble.
  assign w_used = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
  // rst_n gate keeps the request low while reset is held.
  assign w_req  = rst_n && !r_halted && !redirect_valid &&
                  (w_used < (CNT_W + 1)'(DEPTH));

  // A returning word is dropped when a redirect flushes in the same cycle,
  // or when it was issued in the cycle the halt word was enqueued.
  assign w_push     = r_inflight && !redirect_valid && !r_halted;
  assign w_pop      = w_fifo_valid && out_ready && !redirect_valid;
  assign w_halt_hit = w_push && is_halt_opcode(mem_rdata[OPC_MSB:OPC_LSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_halted      <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
      end
      if (w_halt_hit) r_halted <= 1'b1;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   ({mem_rdata, r_inflight_pc}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_valid (w_fifo_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign mem_req   = w_req;
  assign mem_addr  = r_fetch_pc;
  assign out_valid = w_fifo_valid;
  assign out_instr = w_head[ENT_W-1:ADDR_W];
  assign out_pc    = w_head[ADDR_W-1:0];
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch
// Directed bench for instr_prefetch: a per-cycle vector table covering
// streaming, back-pressure and redirect, followed by hand-written sequences
// for halt, PC wrap and mid-operation reset. Memory word k holds k, except
// the halt word placed at address 6 while halt_en is set.
module tb_instr_prefetch;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  logic halt_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  instr_prefetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (halt_en && a == 9'd6) return 32'h7C00_0006;
    return 32'(a);
  endfunction

  // One-cycle-latency instruction memory
  always @(posedge clk) if (mem_req) mem_rdata <= mem_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int rv;
    int rpc;
    int rdy;
    int req;
    int addr;
    int ov;
    int pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rv, input int rpc, input int rdy,
                     input int req, input int addr, input int ov, input int pc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.ov = ov; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          n;
    int          bad_req;
    logic [8:0]  got_pc [16];
    logic [31:0] got_in [16];

    //   rv rpc rdy | req addr ov pc    (cycle index from reset release)
    add(0, 0,   1,   1, 0,   0, 0);    // c0 first request
    add(0, 0,   1,   1, 1,   0, 0);
    add(0, 0,   1,   1, 2,   1, 0);    // c2 first output
    add(0, 0,   1,   1, 3,   1, 1);
    add(0, 0,   1,   1, 4,   1, 2);
    add(0, 0,   1,   1, 5,   1, 3);
    add(0, 0,   0,   1, 6,   1, 4);    // c6 stall begins
    add(0, 0,   0,   1, 7,   1, 4);
    for (int k = 0; k < 8; k++)
      add(0, 0, 0,   0, 8,   1, 4);    // c8..c15 credit exhausted
    add(0, 0,   1,   0, 8,   1, 4);    // c16 resume, bubble at full
    add(0, 0,   0,   1, 8,   1, 5);    // c17 holds 5,6,7, req 8
    add(1, 100, 1,   0, 9,   1, 5);    // c18 redirect, pop ignored
    add(0, 0,   1,   1, 100, 0, 0);
    add(0, 0,   1,   1, 101, 0, 0);
    add(0, 0,   1,   1, 102, 1, 100);  // c21 = redirect + 3
    add(0, 0,   1,   1, 103, 1, 101);
    add(0, 0,   0,   1, 104, 1, 102);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req",   32'(mem_req),   0);
    chk("rst_mem_addr",  32'(mem_addr),  0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr,      0);
    chk("rst_out_pc",    32'(out_pc),    0);
    chk("rst_halted",    32'(halted),    0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      redirect_valid = (vecs[i].rv != 0);
      redirect_pc    = 9'(vecs[i].rpc);
      out_ready      = (vecs[i].rdy != 0);
      #1;
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vecs[i].req));
      if (vecs[i].req != 0)
        chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov != 0) begin
        chk($sformatf("v%0d_pc", i), 32'(out_pc), 32'(vecs[i].pc));
        chk($sformatf("v%0d_instr", i), out_instr, 32'(vecs[i].pc));
      end
      chk($sformatf("v%0d_halted", i), 32'(halted), 0);
      @(negedge clk);
    end

    // Halt: redirect to 4 with a halt word at 6
    halt_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 9'd4; out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    n = 0; bad_req = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (out_valid && out_ready && n < 16) begin
        got_pc[n] = out_pc; got_in[n] = out_instr; n++;
      end
      if (halted && mem_req) bad_req++;
      @(negedge clk);
    end
    chk("halt_count", 32'(n), 3);
    if (n == 3) begin
      chk("halt_pc0", 32'(got_pc[0]), 4);
      chk("halt_pc1", 32'(got_pc[1]), 5);
      chk("halt_pc2", 32'(got_pc[2]), 6);
      chk("halt_instr", got_in[2], 32'h7C00_0006);
    end
    #1;
    chk("halt_flag", 32'(halted), 1);
    chk("halt_noreq", 32'(bad_req), 0);
    chk("halt_req_low", 32'(mem_req), 0);
    chk("halt_out_empty", 32'(out_valid), 0);

    // Redirect to 0 clears halt and restarts fetch
    @(negedge clk);
    halt_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 9'd0;
    #1;
    chk("restart_req_T", 32'(mem_req), 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("restart_halted", 32'(halted), 0);
    chk("restart_req", 32'(mem_req), 1);
    chk("restart_addr", 32'(mem_addr), 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("restart_valid", 32'(out_valid), 1);
    chk("restart_pc", 32'(out_pc), 0);

    // PC wrap: 510, 511, 0, 1
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 9'd510;
    @(negedge clk);
    redirect_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (out_valid && out_ready && n < 16) begin
        got_pc[n] = out_pc; got_in[n] = out_instr; n++;
      end
      @(negedge clk);
    end
    chk("wrap_count_min", 32'(n >= 4), 1);
    if (n >= 4) begin
      chk("wrap_pc0", 32'(got_pc[0]), 510);
      chk("wrap_pc1", 32'(got_pc[1]), 511);
      chk("wrap_pc2", 32'(got_pc[2]), 0);
      chk("wrap_pc3", 32'(got_pc[3]), 1);
      chk("wrap_instr1", got_in[1], 511);
      chk("wrap_instr2", got_in[2], 0);
    end

    // Reset pulse while the buffer is full
    out_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("full_valid", 32'(out_valid), 1);
    chk("full_noreq", 32'(mem_req), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_pc", 32'(out_pc), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("rel_req", 32'(mem_req), 1);
    chk("rel_addr", 32'(mem_addr), 0);
    @(negedge clk);
    #1;
    chk("rel_valid_c1", 32'(out_valid), 0);
    @(negedge clk);
    #1;
    chk("rel_valid_c2", 32'(out_valid), 1);
    chk("rel_pc_c2", 32'(out_pc), 0);
    chk("rel_instr_c2", out_instr, 0);
    @(negedge clk);
    #1;
    chk("rel_pc_c3", 32'(out_pc), 1);
    chk("rel_instr_c3", out_instr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
